gpio_serial_loader: RTL
=======================

# gpio_serial_loader

Sequencer that transfers per-pad 13-bit GPIO configuration words into the daisy-chained GPIO control-block shift register, then pulses the load strobe so all pads latch their new configuration at once. Sits in housekeeping between the GPIO configuration register file (or the mask-programmed defaults vector) and the serial configuration chain. It drives `serial_clock`, `serial_data` and `serial_load`. One transfer is started per `start` pulse.

## Interface
- `NUM_GPIO`, 19: pads in the chain; must be ≥1.
- `WORD_WIDTH`, 13: bits per pad configuration word.
- `CLK_DIV`, 1: `clock` cycles per serial-clock half period; must be ≥1.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_sel`  in  1  sampled with `start`: 0 = register-file words, 1 = defaults vector; held internally for the whole transfer.
- `cfg_word`  in  WORD_WIDTH  register-file word for pad `cfg_idx`; combinational, sampled at end of FETCH.
- `gpio_defaults`  in  NUM_GPIO*WORD_WIDTH  defaults; pad k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- `cfg_idx`  out  $clog2(NUM_GPIO) (min 1)  pad index being fetched.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse at end of transfer.
- `serial_clock`  out  1  chain shift clock.
- `serial_data`  out  1  chain data, MSB of current word first.
- `serial_load`  out  1  chain latch strobe.

## Operation
- States: IDLE, FETCH, LOW, HIGH, LOAD, DONE.
- IDLE: all serial outputs 0, `busy`=0. When `start`=1: latch `src_sel`, set `cfg_idx`=NUM_GPIO-1, bit counter=WORD_WIDTH-1, go to FETCH. When `start`=0, stay.
- FETCH (1 cycle): load the shift register from `cfg_word` (sel 0) or the `gpio_defaults` slice for `cfg_idx` (sel 1). Go to LOW. `serial_clock`=0.
- LOW (CLK_DIV cycles): `serial_clock`=0, `serial_data`=shreg[WORD_WIDTH-1]. Go to HIGH.
- HIGH (CLK_DIV cycles): `serial_clock`=1, `serial_data` held. On exit, shift shreg left by 1 and then:
  - bit counter ≠0: decrement it and go to LOW.
  - bit counter =0 and `cfg_idx`≠0: decrement `cfg_idx`, reset the bit counter, go to FETCH.
  - bit counter =0 and `cfg_idx`=0: go to LOAD.
- Pad order: the highest index is shifted first, so pad 0 ends nearest the chain input and each pad ends in its own control block.
- LOAD (CLK_DIV cycles): `serial_load`=1, `serial_clock`=0, `serial_data`=0. Go to DONE.
- DONE (1 cycle): `done`=1, `busy`=1. Go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- `serial_data` is 0 in IDLE, FETCH, LOAD and DONE.
- The half-period counter is CLK_DIV wide, counts 0..CLK_DIV-1 and clears on every state change.

## Timing
- Reset (synchronous): state=IDLE; `busy`, `done`, `serial_clock`, `serial_data`, `serial_load`=0; `cfg_idx`=0; counters and shreg=0.
- Reset mid-transfer aborts on that edge with no load pulse. The chain holds partial data; the next full transfer overwrites it.
- `start` accepted at edge T: `busy`=1 and FETCH from T+1.
- Per pad: 1 + 2·WORD_WIDTH·CLK_DIV cycles.
- `busy` high for exactly NUM_GPIO·(1+2·WORD_WIDTH·CLK_DIV) + CLK_DIV + 1 cycles.
- `done` is asserted in the last of those cycles; the next `start` is accepted in the following cycle.
- Data is stable for CLK_DIV cycles before and after each `serial_clock` rising edge.
- All outputs are registered or pure state decode; no combinational path from inputs to outputs.

## Test plan
- NUM_GPIO=2, CLK_DIV=1, src_sel=0, words pad1=13'h1803, pad0=13'h0402, start at cycle 0. Required response:
  - `busy` for 56 cycles and `done` in its last cycle.
  - 26 `serial_clock` rising edges.
  - Bits captured on those edges: 1_1000_0000_0011 then 0_0100_0000_0010.
  - One `serial_load` cycle after the 26th edge.
- src_sel=1, `gpio_defaults`={13'h1FFF,13'h0000}, CLK_DIV=2. Required response:
  - 13 ones, then 13 zeros.
  - Each `serial_clock` level lasts 2 cycles.
  - `serial_load` high 2 cycles.
  - `busy` for 2·53+3=109 cycles.
- `start` pulsed again at cycles 5 and 30 of a transfer: ignored. After `done`, a `start` on the next cycle is accepted and `busy` rises one cycle later.
- `reset` asserted at cycle 20 of a transfer: the next cycle shows all outputs 0 and state IDLE, with no `serial_load` pulse. A fresh `start` then completes normally.
- NUM_GPIO=1, CLK_DIV=1, word 13'h1555: alternating 1,0,… on 13 edges; `busy` for 29 cycles.
- `cfg_word` changed mid-word, outside FETCH: the shifted bits still match the value sampled at the end of FETCH.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// Serial loader for the daisy-chained GPIO configuration chain: shifts one word
// per pad (highest pad first, MSB first), then pulses the chain load strobe.
module gpio_serial_loader #(
    parameter int NUM_GPIO   = 19,
    parameter int WORD_WIDTH = 13,
    parameter int CLK_DIV    = 1,
    localparam int IDX_W     = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           src_sel,
    input  logic [WORD_WIDTH-1:0]          cfg_word,
    input  logic [NUM_GPIO*WORD_WIDTH-1:0] gpio_defaults,
    output logic [IDX_W-1:0]               cfg_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           serial_clock,
    output logic                           serial_data,
    output logic                           serial_load
);
    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_GPIO - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(WORD_WIDTH - 1);
    localparam logic [CLK_DIV-1:0] DIV_LAST = CLK_DIV'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, LOAD, DONE} state_t;

    state_t                  state_q;
    logic                    srcSel_q;
    logic [IDX_W-1:0]        cfgIdx_q;
    logic [BIT_W-1:0]        bitCnt_q;
    logic [CLK_DIV-1:0]      divCnt_q;
    logic [WORD_WIDTH-1:0]   shreg_q;
    logic [WORD_WIDTH-1:0]   shreg_d;
    logic [WORD_WIDTH-1:0]   fetchWord;
    logic                    divDone;
    logic                    busy_q;
    logic                    done_q;
    logic                    sclk_q;
    logic                    sdata_q;
    logic                    sload_q;

    // The shift register is loaded at the end of FETCH and shifted when a HIGH phase ends.
    always_comb begin
        fetchWord = srcSel_q ? gpio_defaults[int'(cfgIdx_q)*WORD_WIDTH +: WORD_WIDTH] : cfg_word;
        divDone   = (divCnt_q == DIV_LAST);
        shreg_d   = shreg_q;
        if (state_q == FETCH)
            shreg_d = fetchWord;
        else if (state_q == HIGH && divDone)
            shreg_d = shreg_q << 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            srcSel_q <= 1'b0;
            cfgIdx_q <= '0;
            bitCnt_q <= '0;
            divCnt_q <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            sload_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        srcSel_q <= src_sel;
                        cfgIdx_q <= IDX_LAST;
                        bitCnt_q <= BIT_LAST;
                        divCnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    divCnt_q <= '0;
                    sdata_q  <= shreg_d[WORD_WIDTH-1];
                    state_q  <= LOW;
                end
                LOW: begin
                    if (divDone) begin
                        divCnt_q <= '0;
                        sclk_q   <= 1'b1;
                        state_q  <= HIGH;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (divDone) begin
                        divCnt_q <= '0;
                        sclk_q   <= 1'b0;
                        if (bitCnt_q != '0) begin
                            bitCnt_q <= bitCnt_q - 1'b1;
                            sdata_q  <= shreg_d[WORD_WIDTH-1];
                            state_q  <= LOW;
                        end else if (cfgIdx_q != '0) begin
                            cfgIdx_q <= cfgIdx_q - 1'b1;
                            bitCnt_q <= BIT_LAST;
                            sdata_q  <= 1'b0;
                            state_q  <= FETCH;
                        end else begin
                            sdata_q  <= 1'b0;
                            sload_q  <= 1'b1;
                            state_q  <= LOAD;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (divDone) begin
                        divCnt_q <= '0;
                        sload_q  <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_idx      = cfgIdx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = sload_q;

endmodule
